iob_pcie_chnl_host: RTL and testbench
=====================================

IOB_PCIE_CHNL_HOST -- requirements
Module: iob_pcie_chnl_host

Interface
REQ-001 SHALL have parameters, one per line:
- C_PCI_DATA_WIDTH, 64, channel data width; only 64 is supported.
- LEN_W, 32, transaction length width, in 32-bit words.
- ACK_TO, 1024, RX_ACK timeout in cycles.

REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock; all logic is synchronous to it.
- rst  in  1  synchronous, active-low reset.
- cmd_valid  in  1  RX transaction request.
- cmd_ready  out  1  request accepted when high together with cmd_valid.
- cmd_len  in  LEN_W  RX length in 32-bit words.
- cmd_off  in  LEN_W-1  RX offset.
- cmd_last  in  1  last transaction in the sequence.
- src_data  in  64  RX payload source.
- src_valid  in  1  src_data is valid.
- src_ready  out  1  src_data is consumed this cycle.
- PCIE_CHNL_RX_o  out  1  RX transaction active.
- PCIE_CHNL_RX_LAST_o  out  1  last transaction of the sequence.
- PCIE_CHNL_RX_LEN_o  out  LEN_W  RX length.
- PCIE_CHNL_RX_OFF_o  out  LEN_W-1  RX offset.
- PCIE_CHNL_RX_DATA_o  out  64  RX data.
- PCIE_CHNL_RX_DATA_VALID_o  out  1  RX data is valid.
- PCIE_CHNL_RX_DATA_REN_i  in  1  user consumes RX data.
- PCIE_CHNL_RX_ACK_i  in  1  user acknowledges the RX transaction.
- PCIE_CHNL_TX_i  in  1  user TX transaction active.
- PCIE_CHNL_TX_LEN_i  in  LEN_W  TX length.
- PCIE_CHNL_TX_DATA_i  in  64  TX data.
- PCIE_CHNL_TX_DATA_VALID_i  in  1  TX data is valid.
- PCIE_CHNL_TX_DATA_REN_o  out  1  TX data is consumed.
- PCIE_CHNL_TX_ACK_o  out  1  TX transaction acknowledge.
- snk_data  out  64  TX payload to the sink.
- snk_valid  out  1  snk_data is valid.
- snk_ready  in  1  sink accepts snk_data.
- snk_last  out  1  final beat of the TX transaction.
- err_o  out  1  sticky flag: RX_ACK timeout occurred.

Function
REQ-003 SHALL compute beats as ceil(len/2) = (len+1)>>1, in LEN_W+1 bits so no overflow occurs at the all-ones length.
REQ-004 SHALL place the low 32-bit word in bits 31:0 of each beat; on odd lengths the upper half of the final beat is don't-care.
REQ-005 The RX FSM SHALL use the states R_IDLE, R_REQ, R_DATA.
REQ-006 In R_IDLE, cmd_ready SHALL be 1.
- On cmd_valid, latch len, off and last, clear err_o, and go to R_REQ.
REQ-007 In R_REQ and R_DATA, PCIE_CHNL_RX_o SHALL be 1 and the RX_LEN/OFF/LAST outputs SHALL hold the latched values.
REQ-008 In R_REQ, on RX_ACK_i=1 the FSM SHALL go to R_DATA, or to R_IDLE if len=0.
- If ACK_TO cycles elapse without RX_ACK_i, set err_o=1 and go to R_IDLE.
REQ-009 In R_DATA:
- RX_DATA_VALID_o = src_valid.
- RX_DATA_o = src_data.
- src_ready = RX_DATA_REN_i.
- A beat transfers when valid and ren are both 1.
REQ-010 On the final beat transfer, the FSM SHALL go to R_IDLE, with PCIE_CHNL_RX_o low on the next cycle.
REQ-011 RX_DATA_VALID_o and src_ready SHALL be 0 outside R_DATA.
REQ-012 The TX FSM SHALL use the states T_IDLE, T_ACK, T_DATA, T_WAIT.
REQ-013 In T_IDLE, on PCIE_CHNL_TX_i=1 the FSM SHALL latch TX_LEN_i and go to T_ACK.
REQ-014 In T_ACK, TX_ACK_o SHALL be 1 for exactly one cycle; the FSM then goes to T_DATA, or to T_WAIT if len=0.
REQ-015 In T_DATA:
- TX_DATA_REN_o = snk_ready.
- snk_valid = TX_DATA_VALID_i.
- snk_data = TX_DATA_i.
- snk_last = 1 on the final counted beat.
REQ-016 After the final beat transfer the FSM SHALL go to T_WAIT, then to T_IDLE once PCIE_CHNL_TX_i=0; a held TX never retriggers.
REQ-017 The RX and TX FSMs SHALL run independently, and simultaneous activity SHALL be supported.
REQ-018 Beat counters SHALL saturate at their terminal count; beats beyond the length are never accepted (REN=0 in T_WAIT).

Reset
REQ-019 When rst=0 at a clk edge, both FSMs SHALL go to their IDLE states, all counters to 0, err_o=0, and every output except cmd_ready (1) to 0, including mid-transaction.

Structure
REQ-020 A shared package SHALL hold the RX and TX state encodings and the beat-count function.
REQ-021 One sub-module, iob_pcie_beat_cnt, SHALL provide the load/decrement/terminal-flag counter, instantiated once for RX and once for TX.

Verification
REQ-022 cmd_len=6, immediate ACK, REN always 1 -> 3 beats, RX_o low the cycle after beat 3.
REQ-023 cmd_len=5 -> 3 beats; no 4th src_ready.
REQ-024 No ACK with ACK_TO=16 -> RX_o drops after 16 cycles, err_o=1; the next accepted cmd clears err_o.
REQ-025 TX_LEN=4, TX held high, snk_ready toggling -> 2 beats, one-cycle TX_ACK_o, snk_last on beat 2, no retrigger until TX_i falls.
REQ-026 rst=0 during R_DATA beat 2 of 4 -> all outputs at reset values next cycle; a fresh cmd completes normally.

Source files
------------

// File: rtl/iob_pcie_chnl_host_pkg.sv
// rtl/iob_pcie_chnl_host_pkg.sv - shared state encodings and beat-count helper for the PCIe channel host
package iob_pcie_chnl_host_pkg;

    typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_ACK, T_DATA, T_WAIT} tx_state_t;

    localparam int MAX_LEN_W = 64;

    // Two 32-bit words per 64-bit beat; the extra result bit keeps all-ones lengths from wrapping.
    function automatic logic [MAX_LEN_W:0] beat_count(input logic [MAX_LEN_W-1:0] len);
        return ({1'b0, len} + (MAX_LEN_W+1)'(1)) >> 1;
    endfunction

endpackage

// File: rtl/iob_pcie_beat_cnt.sv
// rtl/iob_pcie_beat_cnt.sv - loadable down-counter with terminal and zero flags
module iob_pcie_beat_cnt #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         last,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign last = (cnt == W'(1));
    assign zero = (cnt == '0);

endmodule

// File: rtl/iob_pcie_chnl_host.sv
// rtl/iob_pcie_chnl_host.sv - host-side RX/TX channel engine bridging payload streams to a PCIe channel
module iob_pcie_chnl_host
    import iob_pcie_chnl_host_pkg::*;
#(
    parameter int C_PCI_DATA_WIDTH = 64,
    parameter int LEN_W            = 32,
    parameter int ACK_TO           = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [LEN_W-1:0]            cmd_len,
    input  logic [LEN_W-2:0]            cmd_off,
    input  logic                        cmd_last,
    input  logic [C_PCI_DATA_WIDTH-1:0] src_data,
    input  logic                        src_valid,
    output logic                        src_ready,
    output logic                        PCIE_CHNL_RX_o,
    output logic                        PCIE_CHNL_RX_LAST_o,
    output logic [LEN_W-1:0]            PCIE_CHNL_RX_LEN_o,
    output logic [LEN_W-2:0]            PCIE_CHNL_RX_OFF_o,
    output logic [C_PCI_DATA_WIDTH-1:0] PCIE_CHNL_RX_DATA_o,
    output logic                        PCIE_CHNL_RX_DATA_VALID_o,
    input  logic                        PCIE_CHNL_RX_DATA_REN_i,
    input  logic                        PCIE_CHNL_RX_ACK_i,
    input  logic                        PCIE_CHNL_TX_i,
    input  logic [LEN_W-1:0]            PCIE_CHNL_TX_LEN_i,
    input  logic [C_PCI_DATA_WIDTH-1:0] PCIE_CHNL_TX_DATA_i,
    input  logic                        PCIE_CHNL_TX_DATA_VALID_i,
    output logic                        PCIE_CHNL_TX_DATA_REN_o,
    output logic                        PCIE_CHNL_TX_ACK_o,
    output logic [C_PCI_DATA_WIDTH-1:0] snk_data,
    output logic                        snk_valid,
    input  logic                        snk_ready,
    output logic                        snk_last,
    output logic                        err_o
);

    localparam int TO_W = $clog2(ACK_TO + 1);

    rx_state_t          rx_state, rx_next;
    tx_state_t          tx_state, tx_next;
    logic [LEN_W-1:0]   rx_len;
    logic [LEN_W-2:0]   rx_off;
    logic               rx_last;
    logic [TO_W-1:0]    to_cnt;
    logic               to_hit;
    logic               rx_load, rx_xfer, rx_active;
    logic               tx_load, tx_xfer;
    logic [LEN_W:0]     rx_beats, tx_beats;
    logic [LEN_W:0]     rx_cnt, tx_cnt;
    logic               rx_cnt_last, rx_cnt_zero, tx_cnt_last, tx_cnt_zero;

    assign rx_beats = (LEN_W+1)'(beat_count(MAX_LEN_W'(cmd_len)));
    assign tx_beats = (LEN_W+1)'(beat_count(MAX_LEN_W'(PCIE_CHNL_TX_LEN_i)));

    assign rx_load   = (rx_state == R_IDLE) && cmd_valid;
    assign rx_active = (rx_state != R_IDLE);
    assign rx_xfer   = (rx_state == R_DATA) && src_valid && PCIE_CHNL_RX_DATA_REN_i;
    assign to_hit    = (to_cnt == TO_W'(ACK_TO - 1));
    assign tx_load   = (tx_state == T_IDLE) && PCIE_CHNL_TX_i;
    assign tx_xfer   = (tx_state == T_DATA) && PCIE_CHNL_TX_DATA_VALID_i && snk_ready;

    iob_pcie_beat_cnt #(.W(LEN_W + 1)) u_rx_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (rx_load),
        .load_val (rx_beats),
        .dec      (rx_xfer),
        .cnt      (rx_cnt),
        .last     (rx_cnt_last),
        .zero     (rx_cnt_zero)
    );

    iob_pcie_beat_cnt #(.W(LEN_W + 1)) u_tx_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (tx_load),
        .load_val (tx_beats),
        .dec      (tx_xfer),
        .cnt      (tx_cnt),
        .last     (tx_cnt_last),
        .zero     (tx_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state <= R_IDLE;
            rx_len   <= '0;
            rx_off   <= '0;
            rx_last  <= 1'b0;
            err_o    <= 1'b0;
            to_cnt   <= '0;
        end else begin
            rx_state <= rx_next;
            if (rx_load) begin
                rx_len  <= cmd_len;
                rx_off  <= cmd_off;
                rx_last <= cmd_last;
                err_o   <= 1'b0;
            end
            // The wait counter only runs while a request is outstanding.
            if (rx_state == R_REQ) begin
                to_cnt <= to_cnt + TO_W'(1);
                if (!PCIE_CHNL_RX_ACK_i && to_hit) begin
                    err_o <= 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            R_IDLE: if (cmd_valid) rx_next = R_REQ;
            R_REQ: begin
                if (PCIE_CHNL_RX_ACK_i) rx_next = rx_cnt_zero ? R_IDLE : R_DATA;
                else if (to_hit)        rx_next = R_IDLE;
            end
            R_DATA: if (rx_xfer && rx_cnt_last) rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
    end

    assign cmd_ready                 = (rx_state == R_IDLE);
    assign PCIE_CHNL_RX_o            = rx_active;
    assign PCIE_CHNL_RX_LEN_o        = rx_active ? rx_len : '0;
    assign PCIE_CHNL_RX_OFF_o        = rx_active ? rx_off : '0;
    assign PCIE_CHNL_RX_LAST_o       = rx_active && rx_last;
    assign PCIE_CHNL_RX_DATA_VALID_o = (rx_state == R_DATA) && src_valid;
    assign PCIE_CHNL_RX_DATA_o       = (rx_state == R_DATA) ? src_data : '0;
    assign src_ready                 = (rx_state == R_DATA) && PCIE_CHNL_RX_DATA_REN_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state <= T_IDLE;
        end else begin
            tx_state <= tx_next;
        end
    end

    // T_WAIT absorbs a TX request held high past completion so it never restarts.
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            T_IDLE: if (PCIE_CHNL_TX_i) tx_next = T_ACK;
            T_ACK:  tx_next = tx_cnt_zero ? T_WAIT : T_DATA;
            T_DATA: if (tx_xfer && tx_cnt_last) tx_next = T_WAIT;
            T_WAIT: if (!PCIE_CHNL_TX_i) tx_next = T_IDLE;
            default: tx_next = T_IDLE;
        endcase
    end

    assign PCIE_CHNL_TX_ACK_o      = (tx_state == T_ACK);
    assign PCIE_CHNL_TX_DATA_REN_o = (tx_state == T_DATA) && snk_ready;
    assign snk_valid               = (tx_state == T_DATA) && PCIE_CHNL_TX_DATA_VALID_i;
    assign snk_data                = (tx_state == T_DATA) ? PCIE_CHNL_TX_DATA_i : '0;
    assign snk_last                = (tx_state == T_DATA) && tx_cnt_last;

endmodule

// File: tb/tb_iob_pcie_chnl_host.sv
// tb/tb_iob_pcie_chnl_host.sv - directed self-checking bench for iob_pcie_chnl_host
module tb_iob_pcie_chnl_host;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_last = 1'b0;
    logic [31:0] cmd_len = '0;
    logic [30:0] cmd_off = '0;
    logic [63:0] src_data = '0;
    logic        src_valid = 1'b0, src_ready;
    logic        rx_o, rx_last_o, rx_dv_o;
    logic [31:0] rx_len_o;
    logic [30:0] rx_off_o;
    logic [63:0] rx_data_o;
    logic        rx_ren = 1'b0, rx_ack = 1'b0;
    logic        tx_i = 1'b0, tx_dv = 1'b0, tx_ren_o, tx_ack_o;
    logic [31:0] tx_len = '0;
    logic [63:0] tx_data = '0;
    logic [63:0] snk_data;
    logic        snk_valid, snk_ready = 1'b0, snk_last, err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    iob_pcie_chnl_host #(.C_PCI_DATA_WIDTH(64), .LEN_W(32), .ACK_TO(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_off(cmd_off), .cmd_last(cmd_last),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .PCIE_CHNL_RX_o(rx_o), .PCIE_CHNL_RX_LAST_o(rx_last_o),
        .PCIE_CHNL_RX_LEN_o(rx_len_o), .PCIE_CHNL_RX_OFF_o(rx_off_o),
        .PCIE_CHNL_RX_DATA_o(rx_data_o), .PCIE_CHNL_RX_DATA_VALID_o(rx_dv_o),
        .PCIE_CHNL_RX_DATA_REN_i(rx_ren), .PCIE_CHNL_RX_ACK_i(rx_ack),
        .PCIE_CHNL_TX_i(tx_i), .PCIE_CHNL_TX_LEN_i(tx_len),
        .PCIE_CHNL_TX_DATA_i(tx_data), .PCIE_CHNL_TX_DATA_VALID_i(tx_dv),
        .PCIE_CHNL_TX_DATA_REN_o(tx_ren_o), .PCIE_CHNL_TX_ACK_o(tx_ack_o),
        .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
        .snk_last(snk_last), .err_o(err)
    );

    // Accept one RX command with immediate ACK and REN held high; report beats and RX-active cycles.
    task automatic rx_run(input logic [31:0] len, input logic [30:0] off, input logic lst,
                          output int beats, output int hi, output int data_bad,
                          output logic [31:0] req_len, output logic [30:0] req_off, output logic req_last);
        beats = 0; hi = 0; data_bad = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = len; cmd_off = off; cmd_last = lst;
        @(negedge clk);
        cmd_valid = 1'b0; #1;
        req_len = rx_len_o; req_off = rx_off_o; req_last = rx_last_o;
        rx_ack = 1'b1; rx_ren = 1'b1; src_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            src_data = {32'hB000_0000 | 32'(i), 32'hA000_0000 | 32'(i)};
            #1;
            if (!rx_o) break;
            hi++;
            if (rx_dv_o && src_ready) begin
                beats++;
                if (rx_data_o !== src_data) data_bad++;
            end
        end
        rx_ack = 1'b0; rx_ren = 1'b0; src_valid = 1'b0;
    endtask

    // Raise TX with the given length and run a bounded window; TX stays high on return.
    task automatic tx_run(input logic [31:0] len, input logic toggle, input int exp_beats, input int cycles,
                          output int acks, output int beats, output int last_bad, output int data_bad);
        acks = 0; beats = 0; last_bad = 0; data_bad = 0;
        @(negedge clk);
        tx_i = 1'b1; tx_len = len; tx_dv = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            snk_ready = toggle ? i[0] : 1'b1;
            tx_data = 64'hC0DE_0000_0000_0000 + 64'(i);
            #1;
            if (tx_ack_o) acks++;
            if (snk_valid && tx_ren_o) begin
                beats++;
                if (snk_last !== (beats == exp_beats)) last_bad++;
                if (snk_data !== tx_data) data_bad++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        n_cmp++; if (rx_o !== 1'b0) begin n_bad++; $display("FAIL reset_rx_o: got %b want 0", rx_o); end
        n_cmp++; if (src_ready !== 1'b0) begin n_bad++; $display("FAIL reset_src_ready: got %b want 0", src_ready); end
        n_cmp++; if (tx_ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_tx_ack: got %b want 0", tx_ack_o); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (rx_len_o !== 32'd0) begin n_bad++; $display("FAIL reset_rx_len: got %0d want 0", rx_len_o); end
        rst = 1'b1;
    endtask

    task automatic test_rx_even;
        int beats, hi, dbad; logic [31:0] l; logic [30:0] o; logic lst;
        rx_run(32'd6, 31'd3, 1'b1, beats, hi, dbad, l, o, lst);
        n_cmp++; if (l !== 32'd6) begin n_bad++; $display("FAIL rx6_len_o: got %0d want 6", l); end
        n_cmp++; if (o !== 31'd3) begin n_bad++; $display("FAIL rx6_off_o: got %0d want 3", o); end
        n_cmp++; if (lst !== 1'b1) begin n_bad++; $display("FAIL rx6_last_o: got %b want 1", lst); end
        n_cmp++; if (beats != 3) begin n_bad++; $display("FAIL rx6_beats: got %0d want 3", beats); end
        n_cmp++; if (hi != 3) begin n_bad++; $display("FAIL rx6_active_cycles: got %0d want 3", hi); end
        n_cmp++; if (dbad != 0) begin n_bad++; $display("FAIL rx6_data: got %0d bad want 0", dbad); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rx6_idle_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_rx_odd;
        int beats, hi, dbad; logic [31:0] l; logic [30:0] o; logic lst;
        rx_run(32'd5, 31'h7FFF_FFFF, 1'b0, beats, hi, dbad, l, o, lst);
        n_cmp++; if (o !== 31'h7FFF_FFFF) begin n_bad++; $display("FAIL rx5_off_o: got %0h want 7fffffff", o); end
        n_cmp++; if (lst !== 1'b0) begin n_bad++; $display("FAIL rx5_last_o: got %b want 0", lst); end
        n_cmp++; if (beats != 3) begin n_bad++; $display("FAIL rx5_beats: got %0d want 3", beats); end
        n_cmp++; if (hi != 3) begin n_bad++; $display("FAIL rx5_active_cycles: got %0d want 3", hi); end
        rx_ren = 1'b1; src_valid = 1'b1; #1;
        n_cmp++; if (src_ready !== 1'b0) begin n_bad++; $display("FAIL rx5_no_4th_ready: got %b want 0", src_ready); end
        rx_ren = 1'b0; src_valid = 1'b0;
    endtask

    task automatic test_rx_timeout;
        int hi = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = 32'd4; cmd_off = '0; cmd_last = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0; #1;
        for (int i = 0; i < 40; i++) begin
            if (!rx_o) break;
            hi++;
            @(negedge clk); #1;
        end
        n_cmp++; if (hi != 16) begin n_bad++; $display("FAIL to_active_cycles: got %0d want 16", hi); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL to_err_set: got %b want 1", err); end
        @(negedge clk); #1;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL to_err_sticky: got %b want 1", err); end
        cmd_valid = 1'b1; cmd_len = 32'd2;
        @(negedge clk);
        cmd_valid = 1'b0; #1;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL to_err_clear: got %b want 0", err); end
        rx_ack = 1'b1; rx_ren = 1'b1; src_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (!rx_o) break;
        end
        rx_ack = 1'b0; rx_ren = 1'b0; src_valid = 1'b0;
        n_cmp++; if (rx_o !== 1'b0) begin n_bad++; $display("FAIL to_followup_done: got %b want 0", rx_o); end
    endtask

    task automatic test_tx;
        int acks, beats, lbad, dbad;
        tx_run(32'd4, 1'b1, 2, 14, acks, beats, lbad, dbad);
        n_cmp++; if (acks != 1) begin n_bad++; $display("FAIL tx4_acks: got %0d want 1", acks); end
        n_cmp++; if (beats != 2) begin n_bad++; $display("FAIL tx4_beats: got %0d want 2", beats); end
        n_cmp++; if (lbad != 0) begin n_bad++; $display("FAIL tx4_snk_last: got %0d bad want 0", lbad); end
        n_cmp++; if (dbad != 0) begin n_bad++; $display("FAIL tx4_data: got %0d bad want 0", dbad); end
        snk_ready = 1'b1; #1;
        n_cmp++; if (tx_ren_o !== 1'b0) begin n_bad++; $display("FAIL tx4_wait_ren: got %b want 0", tx_ren_o); end
        tx_i = 1'b0;
        @(negedge clk);
        tx_i = 1'b1; tx_len = 32'd0;
        @(negedge clk); #1;
        n_cmp++; if (tx_ack_o !== 1'b1) begin n_bad++; $display("FAIL tx0_ack: got %b want 1", tx_ack_o); end
        @(negedge clk); #1;
        n_cmp++; if (tx_ack_o !== 1'b0) begin n_bad++; $display("FAIL tx0_ack_one_cycle: got %b want 0", tx_ack_o); end
        n_cmp++; if (tx_ren_o !== 1'b0) begin n_bad++; $display("FAIL tx0_no_data: got %b want 0", tx_ren_o); end
        tx_i = 1'b0; tx_dv = 1'b0; snk_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_simultaneous;
        int rb, rh, rd, ta, tb, tl, td; logic [31:0] l; logic [30:0] o; logic lst;
        fork
            rx_run(32'd3, 31'd1, 1'b1, rb, rh, rd, l, o, lst);
            tx_run(32'd3, 1'b0, 2, 8, ta, tb, tl, td);
        join
        n_cmp++; if (rb != 2) begin n_bad++; $display("FAIL sim_rx_beats: got %0d want 2", rb); end
        n_cmp++; if (tb != 2) begin n_bad++; $display("FAIL sim_tx_beats: got %0d want 2", tb); end
        n_cmp++; if (tl != 0) begin n_bad++; $display("FAIL sim_tx_last: got %0d bad want 0", tl); end
        tx_i = 1'b0; tx_dv = 1'b0; snk_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int beats, hi, dbad; logic [31:0] l; logic [30:0] o; logic lst;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = 32'd8; cmd_off = 31'd5; cmd_last = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; rx_ack = 1'b1; rx_ren = 1'b1; src_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (src_ready !== 1'b1) begin n_bad++; $display("FAIL mid_in_beat2: got %b want 1", src_ready); end
        rst = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (rx_o !== 1'b0) begin n_bad++; $display("FAIL mid_rx_o: got %b want 0", rx_o); end
        n_cmp++; if (src_ready !== 1'b0) begin n_bad++; $display("FAIL mid_src_ready: got %b want 0", src_ready); end
        n_cmp++; if (rx_dv_o !== 1'b0) begin n_bad++; $display("FAIL mid_rx_dv: got %b want 0", rx_dv_o); end
        n_cmp++; if (rx_len_o !== 32'd0) begin n_bad++; $display("FAIL mid_rx_len: got %0d want 0", rx_len_o); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL mid_cmd_ready: got %b want 1", cmd_ready); end
        rst = 1'b1; rx_ack = 1'b0; rx_ren = 1'b0; src_valid = 1'b0;
        rx_run(32'd2, 31'd0, 1'b0, beats, hi, dbad, l, o, lst);
        n_cmp++; if (beats != 1) begin n_bad++; $display("FAIL mid_fresh_beats: got %0d want 1", beats); end
        n_cmp++; if (l !== 32'd2) begin n_bad++; $display("FAIL mid_fresh_len: got %0d want 2", l); end
    endtask

    initial begin
        test_reset;
        test_rx_even;
        test_rx_odd;
        test_rx_timeout;
        test_tx;
        test_simultaneous;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
